leds_seq: RTL and testbench
===========================

# leds_seq

LED pattern sequencer driving the 8-bit LED port. Accepts one command at a time over a valid/ready handshake and plays it on `LPORT`. Each command selects an animation: off, static, blink, rotate or bounce. Steps advance on a prescaled tick, and a command runs for a fixed step count or forever. It sits between user logic (or a UART command decoder) and the board LEDs.

## Interface
- `DIV`, 12000000 — prescaler period in clk cycles, one step per tick; legal range ≥1. The default gives 1 s at 12 MHz. Benches use 4.
- `clk`  in  1  system clock, all logic on rising edge
- `rstn`  in  1  synchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted
- `cmd_mode`  in  3  0 OFF, 1 STATIC, 2 BLINK, 3 ROTL, 4 ROTR, 5 BOUNCE, 6–7 treated as OFF
- `cmd_pattern`  in  8  initial/static LED pattern
- `cmd_steps`  in  8  ticks to run; 0 = run forever
- `LPORT`  out  8  LED port, registered
- `busy`  out  1  animation running (state RUN)
- `done`  out  1  one-cycle pulse on command completion

## Operation
- One clock only, with synchronous active-low reset. All state updates on the rising edge of `clk`. Reset is sampled only on the clock edge.
- **States:** IDLE, RUN.
- **Handshake:**
  - `cmd_ready` is 1 in IDLE.
  - In RUN, `cmd_ready` is 1 only if the current run is infinite (steps = 0). Otherwise it is 0.
  - `cmd_ready` is forced 0 while `rstn`=0.
  - A command is accepted on an edge where `cmd_valid && cmd_ready`.
- **Accepting OFF / STATIC:**
  - `LPORT` ← 0x00 (OFF) or `cmd_pattern` (STATIC).
  - State goes to IDLE and `done` pulses.
  - `cmd_steps` is ignored.
- **Accepting BLINK / ROTL / ROTR / BOUNCE:**
  - `LPORT` ← `cmd_pattern`.
  - Prescaler ← 0, remaining ← `cmd_steps`, bounce direction ← left.
  - State goes to RUN.
- **Prescaler:** counts 0..DIV-1 in RUN. `tick` is asserted when count = DIV-1, then count wraps to 0. Width is $clog2(DIV), minimum 1 bit.
- **Step on tick:**
  - BLINK: `LPORT` ← `LPORT` ^ stored pattern, alternating pattern and 0x00.
  - ROTL: rotate left by 1 (bit7→bit0).
  - ROTR: rotate right by 1 (bit0→bit7).
  - BOUNCE, direction left: if `LPORT[7]`, direction ← right and rotate right; else rotate left.
  - BOUNCE, direction right: if `LPORT[0]`, direction ← left and rotate left; else rotate right.
- **Step count:**
  - If remaining ≠ 0: decrement on each tick.
  - On the tick where remaining = 1, apply the step, go to IDLE and pulse `done`. `LPORT` holds the final pattern.
  - If remaining = 0 at start: never terminates.
- **Boundary cases:**
  - Pattern 0x00 in any animation keeps `LPORT` at 0x00, and steps still count.
  - Pattern 0xFF in BOUNCE: reverses every tick; rotation of 0xFF stays 0xFF.
  - Preemption: a new command accepted during an infinite RUN restarts from the accept rules. There is no `done` for the aborted run.
  - If a tick and an accept coincide, the accept wins and the tick is discarded.
  - Reset mid-run: immediate return to IDLE on that edge. The run is lost and no `done` is issued.

## Timing
- **Reset values:** `LPORT`=0x00, `busy`=0, `done`=0, state IDLE, prescaler 0, remaining 0, direction left.
- **Accept latency:** with the accept on edge k, the new `LPORT` is visible from k+1.
- **Busy:** `busy` rises at k+1 for animated modes.
- **First step:** visible after edge k+DIV; subsequent steps every DIV cycles.
- **Finite run of N steps:** the final step and the `done` pulse appear together, after edge k+N·DIV. `busy` falls the same cycle and `cmd_ready` returns to 1 the same cycle.
- **Static/off commands:** `done` is high exactly during cycle k+1.
- **DIV=1:** one step per cycle.
- **Back-to-back:** a command held valid during `done` is accepted that cycle, with no idle gap required.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles mid-ROTL, then release → `LPORT`=0x00, `busy`=0, `cmd_ready`=0 during reset and 1 after release.
- **STATIC:** STATIC 0xA5 → `LPORT`=0xA5 in the next cycle, `done` high 1 cycle, `busy` stays 0.
- **ROTL finite (DIV=4):** ROTL 0x81 with steps=3 → `LPORT` 0x81, 0x03, 0x06, 0x0C, changing every 4 cycles. `done` coincides with 0x0C, after which `busy`=0.
- **BOUNCE infinite (DIV=4):** BOUNCE 0x01 with steps=0 → `LPORT` runs 0x02…0x80, 0x40…0x01, 0x02 (period 14 ticks). `cmd_ready` stays 1 and `done` never fires.
- **Preempt and collision:** during an infinite BLINK 0x0F, issue STATIC 0x3C on a tick cycle → `LPORT`=0x3C next cycle, no blink toggle occurs, and a single `done` is issued for the STATIC command.
- **Reserved mode and hold-off:** mode 7 with pattern 0xFF → `LPORT`=0x00 and `done` pulses. During a finite ROTR run, a held `cmd_valid` is not accepted until the cycle `done` is high.

Source files
------------

// File: rtl/leds_seq.sv
// LED pattern sequencer: accepts one command over valid/ready and plays an
// off/static/blink/rotate/bounce animation on LPORT, one step per prescaler tick.
module leds_seq #(
  parameter int DIV = 12000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [7:0] cmd_pattern,
  input  logic [7:0] cmd_steps,
  output logic [7:0] LPORT,
  output logic       busy,
  output logic       done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [2:0] M_OFF    = 3'd0;
  localparam logic [2:0] M_STATIC = 3'd1;
  localparam logic [2:0] M_BLINK  = 3'd2;
  localparam logic [2:0] M_ROTL   = 3'd3;
  localparam logic [2:0] M_ROTR   = 3'd4;
  localparam logic [2:0] M_BOUNCE = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [2:0]      mode;
  logic [7:0]      pat;
  logic [7:0]      remain;
  logic [PW-1:0]   pcnt;
  logic            dir_r;
  logic            tick;
  logic            accept;
  logic [7:0]      step_led;
  logic            step_dir;

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr1(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  // remain is only zero in RUN for an endless run, which may be preempted
  assign cmd_ready = rstn && ((state == IDLE) || (remain == 8'd0));
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state == RUN) && (pcnt == PMAX);
  assign busy      = (state == RUN);

  always_comb begin
    step_led = LPORT;
    step_dir = dir_r;
    case (mode)
      M_BLINK: step_led = LPORT ^ pat;
      M_ROTL:  step_led = rotl1(LPORT);
      M_ROTR:  step_led = rotr1(LPORT);
      M_BOUNCE: begin
        if (!dir_r) begin
          if (LPORT[7]) begin
            step_dir = 1'b1;
            step_led = rotr1(LPORT);
          end else begin
            step_led = rotl1(LPORT);
          end
        end else begin
          if (LPORT[0]) begin
            step_dir = 1'b0;
            step_led = rotl1(LPORT);
          end else begin
            step_led = rotr1(LPORT);
          end
        end
      end
      default: ;
    endcase
  end

  // accept has priority over a coincident tick, which is simply dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      LPORT  <= 8'h00;
      done   <= 1'b0;
      pcnt   <= '0;
      remain <= 8'd0;
      dir_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (cmd_mode)
          M_STATIC: begin
            LPORT <= cmd_pattern;
            state <= IDLE;
            done  <= 1'b1;
          end
          M_BLINK, M_ROTL, M_ROTR, M_BOUNCE: begin
            LPORT  <= cmd_pattern;
            pat    <= cmd_pattern;
            mode   <= cmd_mode;
            pcnt   <= '0;
            remain <= cmd_steps;
            dir_r  <= 1'b0;
            state  <= RUN;
          end
          default: begin
            LPORT <= 8'h00;
            state <= IDLE;
            done  <= 1'b1;
          end
        endcase
      end else if (state == RUN) begin
        if (tick) begin
          pcnt  <= '0;
          LPORT <= step_led;
          dir_r <= step_dir;
          if (remain != 8'd0) begin
            remain <= remain - 8'd1;
            if (remain == 8'd1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_leds_seq.sv
// Self-checking bench for leds_seq with DIV=4: directed scenarios plus a
// randomized command stream compared against a step-count based model.
module tb_leds_seq;

  localparam int DIV = 4;

  logic       clk;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [7:0] cmd_pattern;
  logic [7:0] cmd_steps;
  logic [7:0] LPORT;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  leds_seq #(.DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_pattern(cmd_pattern), .cmd_steps(cmd_steps),
    .LPORT(LPORT), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED value after n completed steps of a command, from the animation rules
  function automatic logic [7:0] model_led(input int mode, input logic [7:0] p, input int n);
    logic [15:0] w;
    logic [7:0]  v;
    bit          right;
    w = {p, p};
    case (mode)
      1: return p;
      2: return (n % 2 == 1) ? 8'h00 : p;
      3: begin w = w << (n % 8); return w[15:8]; end
      4: begin w = w >> (n % 8); return w[7:0]; end
      5: begin
        v = p;
        right = 0;
        for (int i = 0; i < n; i++) begin
          if (!right && v[7]) right = 1;
          else if (right && v[0]) right = 0;
          else right = right;
          if (right && !(v[0] && !v[7] && i >= 0 && 0)) v = right ? {v[0], v[7:1]} : v;
          else v = {v[6:0], v[7]};
        end
        return v;
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit animated(input int mode);
    return (mode >= 2) && (mode <= 5);
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int mode, input logic [7:0] p, input logic [7:0] n);
    cmd_mode    = 3'(mode);
    cmd_pattern = p;
    cmd_steps   = n;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 3'd0;
    cmd_pattern = 8'h00;
    cmd_steps = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (LPORT !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL por_state got led=%h busy=%b done=%b rdy=%b want 00 0 0 0", LPORT, busy, done, cmd_ready);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL por_ready got %b want 1", cmd_ready);
    end
    issue(3, 8'h81, 8'd0);
    repeat (6) step();
    checks++;
    if (LPORT !== model_led(3, 8'h81, 6 / DIV) || busy !== 1'b1) begin
      errors++;
      $display("FAIL rotl_before_reset got led=%h busy=%b want %h 1", LPORT, busy, model_led(3, 8'h81, 1));
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_comb got %b want 0", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (LPORT !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d] got led=%h busy=%b done=%b rdy=%b want 00 0 0 0", i, LPORT, busy, done, cmd_ready);
      end
    end
    rstn = 1'b1;
    #1;
    step();
    checks++;
    if (LPORT !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got led=%h busy=%b done=%b rdy=%b want 00 0 0 1", LPORT, busy, done, cmd_ready);
    end
  endtask

  task automatic test_static;
    issue(1, 8'hA5, 8'($urandom_range(0, 255)));
    checks++;
    if (LPORT !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL static_accept got led=%h done=%b busy=%b want a5 1 0", LPORT, done, busy);
    end
    step();
    checks++;
    if (LPORT !== 8'hA5 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL static_hold got led=%h done=%b busy=%b rdy=%b want a5 0 0 1", LPORT, done, busy, cmd_ready);
    end
  endtask

  task automatic test_rotl_finite;
    logic [7:0] seq [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
    issue(3, 8'h81, 8'd3);
    for (int t = 0; t <= 3 * DIV; t++) begin
      checks++;
      if (LPORT !== seq[t / DIV] || busy !== (t < 3 * DIV) || done !== (t == 3 * DIV)) begin
        errors++;
        $display("FAIL rotl_finite t=%0d got led=%h busy=%b done=%b want %h %b %b",
                 t, LPORT, busy, done, seq[t / DIV], t < 3 * DIV, t == 3 * DIV);
      end
      if (t < 3 * DIV) step();
    end
    step();
    checks++;
    if (LPORT !== 8'h0C || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rotl_after got led=%h busy=%b done=%b rdy=%b want 0c 0 0 1", LPORT, busy, done, cmd_ready);
    end
  endtask

  task automatic test_bounce_infinite;
    int pos;
    logic [7:0] want;
    issue(5, 8'h01, 8'd0);
    for (int t = 0; t <= 30 * DIV; t++) begin
      // single lit LED walks 0..7..0 with period 14 ticks
      pos = (t / DIV) % 14;
      want = (pos <= 7) ? 8'(1 << pos) : 8'(1 << (14 - pos));
      checks++;
      if (LPORT !== want || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bounce t=%0d got led=%h rdy=%b done=%b busy=%b want %h 1 0 1", t, LPORT, cmd_ready, done, busy, want);
      end
      step();
    end
  endtask

  task automatic test_preempt_collision;
    int ndone;
    issue(2, 8'h0F, 8'd0);
    repeat (2 * DIV - 1) step();
    checks++;
    if (LPORT !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL blink_phase got led=%h busy=%b want 00 1", LPORT, busy);
    end
    // this accept lands on the second tick edge
    issue(1, 8'h3C, 8'd5);
    checks++;
    if (LPORT !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt got led=%h done=%b busy=%b want 3c 1 0", LPORT, done, busy);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || LPORT !== 8'h3C) begin
      errors++;
      $display("FAIL preempt_after got extra_done=%0d led=%h want 0 3c", ndone, LPORT);
    end
  endtask

  task automatic test_reserved_holdoff;
    issue(7, 8'hFF, 8'd9);
    checks++;
    if (LPORT !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved got led=%h done=%b busy=%b want 00 1 0", LPORT, done, busy);
    end
    issue(4, 8'h01, 8'd2);
    cmd_mode = 3'd1;
    cmd_pattern = 8'h55;
    cmd_steps = 8'd0;
    cmd_valid = 1'b1;
    for (int t = 0; t <= 2 * DIV; t++) begin
      checks++;
      if (cmd_ready !== (t == 2 * DIV) || done !== (t == 2 * DIV) || LPORT !== model_led(4, 8'h01, t / DIV)) begin
        errors++;
        $display("FAIL holdoff t=%0d got rdy=%b done=%b led=%h want %b %b %h",
                 t, cmd_ready, done, LPORT, t == 2 * DIV, t == 2 * DIV, model_led(4, 8'h01, t / DIV));
      end
      if (t < 2 * DIV) step();
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (LPORT !== 8'h55 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got led=%h done=%b busy=%b want 55 1 0", LPORT, done, busy);
    end
  endtask

  task automatic test_random;
    int mode, n, runlen, k;
    logic [7:0] p;
    bit fin, exp_busy, exp_done;
    for (int c = 0; c < 40; c++) begin
      mode = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: p = 8'h00;
        1: p = 8'hFF;
        default: p = 8'($urandom);
      endcase
      n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
      if (!animated(mode)) runlen = 0;
      else if (n == 0) runlen = $urandom_range(2, 40);
      else runlen = n * DIV;
      fin = animated(mode) && (n != 0);
      issue(mode, p, 8'(n));
      for (int t = 0; t <= runlen; t++) begin
        k = t / DIV;
        exp_busy = animated(mode) && !(fin && t == runlen);
        exp_done = !animated(mode) || (fin && t == runlen);
        checks++;
        if (LPORT !== model_led(mode, p, k) || busy !== exp_busy || done !== exp_done || cmd_ready !== !(fin && t < runlen)) begin
          errors++;
          $display("FAIL rand c=%0d m=%0d p=%h n=%0d t=%0d got led=%h busy=%b done=%b rdy=%b want %h %b %b %b",
                   c, mode, p, n, t, LPORT, busy, done, cmd_ready, model_led(mode, p, k), exp_busy, exp_done,
                   !(fin && t < runlen));
        end
        if (t < runlen) step();
      end
    end
    issue(0, 8'hAA, 8'd0);
    checks++;
    if (LPORT !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_off got led=%h done=%b busy=%b want 00 1 0", LPORT, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_rotl_finite();
    test_bounce_infinite();
    test_preempt_collision();
    test_reserved_holdoff();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
